// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous prefetch FIFO with flush; flush overrides push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC, one-deep memory read tracking, prefetch FIFO with response bypass.
// Optional sticky misaligned-redirect flag when FETCH_MISALIGN_CHECK_EN is defined.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = 10,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic              misalign_err
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc;
  logic [31:0]   pc_p1;
  logic          vld_p1;
  logic [CW-1:0] occ;
  logic [CW:0]   budget;
  logic          resp_vld;
  logic          fifo_vld;
  logic          pop;
  logic          fifo_push;
  logic          fifo_pop;
  logic          issue;
  fetch_entry_t  resp_entry;
  fetch_entry_t  fifo_head;
  fetch_entry_t  head;
  fetch_entry_t  last_q;

  // Stage p0: issue decision and memory request
  assign budget    = (CW+1)'(occ) + (CW+1)'(vld_p1) - (CW+1)'(pop);
  assign issue     = !reset && !redirect_valid && (budget < (CW+1)'(DEPTH));
  assign imem_req  = issue;
  assign imem_addr = issue ? pc[ADDR_W+1:2] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      vld_p1 <= 1'b0;
    end else begin
      if (redirect_valid) pc <= align_word(redirect_pc);
      else if (issue)     pc <= pc + 32'd4;
      vld_p1 <= issue;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= pc;
  end

  // Stage p1: response arrives; presented directly when the FIFO is empty
  assign resp_entry = '{pc: pc_p1, instr: imem_rdata};
  assign resp_vld   = vld_p1 && !redirect_valid;
  assign fifo_vld   = (occ != '0);
  assign out_valid  = fifo_vld || resp_vld;
  assign pop        = out_valid && out_ready;
  assign fifo_pop   = pop && fifo_vld;
  assign fifo_push  = resp_vld && !(pop && !fifo_vld);
  assign head       = fifo_vld ? fifo_head : resp_entry;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (resp_entry),
    .rdata (fifo_head),
    .count (occ)
  );

  // Output hold: last presented entry stays visible while nothing is valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          last_q <= '0;
    else if (out_valid) last_q <= head;
  end

  always_comb begin
    out_pc    = last_q.pc;
    out_instr = last_q.instr;
    if (out_valid) begin
      out_pc    = head.pc;
      out_instr = head.instr;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               misalign_err <= 1'b0;
    else if (redirect_valid) misalign_err <= |redirect_pc[1:0];
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a stream-level reference model and literal timing checks.
module tb_fetch_controller;
  import fetch_pkg::*;

  localparam int          ADDR_W = 10;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata = 32'h0;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic              misalign_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_controller #(
    .RESET_PC (RST_PC),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_err   (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word n holds n
  always @(posedge clk) begin
    imem_rdata <= imem_req ? {{(32-ADDR_W){1'b0}}, imem_addr} : INSTR_NOP;
  end

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {20'h0, 2'b00, a[11:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: consecutive PC stream per redirect/reset epoch
  logic [31:0] exp_out_pc = RST_PC;
  logic [31:0] exp_req_pc = RST_PC;
  logic [31:0] last_pc    = 32'h0;
  logic [31:0] last_instr = 32'h0;
  int          outstanding = 0;
  logic        exp_mis = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      chk("m_rst_valid", {31'h0, out_valid}, 32'h0);
      chk("m_rst_req",   {31'h0, imem_req},  32'h0);
      chk("m_rst_pc",    out_pc,    32'h0);
      chk("m_rst_instr", out_instr, 32'h0);
      exp_out_pc  = RST_PC;
      exp_req_pc  = RST_PC;
      last_pc     = 32'h0;
      last_instr  = 32'h0;
      outstanding = 0;
      exp_mis     = 1'b0;
    end else begin
      if (redirect_valid) chk("m_no_issue_on_redirect", {31'h0, imem_req}, 32'h0);
      if (imem_req) begin
        chk("m_req_addr", {22'h0, imem_addr}, {22'h0, exp_req_pc[11:2]});
        exp_req_pc  = exp_req_pc + 32'd4;
        outstanding = outstanding + 1;
      end
      if (out_valid) begin
        chk("m_out_pc",    out_pc,    exp_out_pc);
        chk("m_out_instr", out_instr, memword(exp_out_pc));
        last_pc    = out_pc;
        last_instr = out_instr;
      end else begin
        chk("m_hold_pc",    out_pc,    last_pc);
        chk("m_hold_instr", out_instr, last_instr);
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("m_misalign", {31'h0, misalign_err}, {31'h0, exp_mis});
`endif
      if (out_valid && out_ready) begin
        exp_out_pc  = exp_out_pc + 32'd4;
        outstanding = outstanding - 1;
      end
      chk("m_buffer_bound", {31'h0, outstanding <= DEPTH}, 32'h1);
      if (redirect_valid) begin
        exp_out_pc  = redirect_pc & 32'hFFFF_FFFC;
        exp_req_pc  = redirect_pc & 32'hFFFF_FFFC;
        outstanding = 0;
        exp_mis     = |redirect_pc[1:0];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc_e, input logic [31:0] ins_e);
    @(negedge clk);
    chk({name, "_valid"}, {31'h0, out_valid}, 32'h1);
    chk({name, "_pc"},    out_pc,    pc_e);
    chk({name, "_instr"}, out_instr, ins_e);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int n_req;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_imem_addr", {22'h0, imem_addr}, 32'h0);

    // Release and stream
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rel_req",   {31'h0, imem_req},  32'h1);
    chk("rel_valid", {31'h0, out_valid}, 32'h0);
    cyc(); expect_out("stream0", 32'h0, 32'h0);
    cyc(); expect_out("stream1", 32'h4, 32'h1);
    cyc(); expect_out("stream2", 32'h8, 32'h2);
    repeat (6) cyc();

    // Mid-stream reset, then restart with decode stalled
    reset = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("async_rst_req",   {31'h0, imem_req},  32'h0);
    repeat (2) cyc();
    reset = 1'b0;
    n_req = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req) n_req++;
    end
    chk("stall_req_count", n_req, 32'd2);
    chk("stall_head_pc", out_pc, 32'h0);
    cyc(); out_ready = 1'b1;
    expect_out("resume0", 32'h0, 32'h0);
    cyc(); expect_out("resume1", 32'h4, 32'h1);
    cyc(); expect_out("resume2", 32'h8, 32'h2);
    repeat (3) cyc();

    // Redirect with a full FIFO
    out_ready = 1'b0;
    repeat (4) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc();
    redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("redir_valid_n1", {31'h0, out_valid}, 32'h0);
    chk("redir_req_n1",   {31'h0, imem_req},  32'h1);
    chk("redir_addr_n1",  {22'h0, imem_addr}, 32'h10);
    cyc(); expect_out("redir_n2", 32'h40, 32'h10);
    cyc(); expect_out("redir_n3", 32'h44, 32'h11);
    repeat (4) cyc();

    // Redirect coincident with a FIFO pop and an in-flight response
    out_ready = 1'b0;
    cyc();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    chk("coinc_pop_valid", {31'h0, out_valid}, 32'h1);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("coinc_valid_n1", {31'h0, out_valid}, 32'h0);
    cyc(); expect_out("coinc_n2", 32'h100, 32'h40);
    repeat (3) cyc();

    // Misaligned target, then aligned target
    redirect_to(32'h42);
`ifdef FETCH_MISALIGN_CHECK_EN
    @(negedge clk);
    chk("misalign_set", {31'h0, misalign_err}, 32'h1);
`endif
    cyc(); expect_out("misalign_target", 32'h40, 32'h10);
    repeat (3) cyc();
    redirect_to(32'h80);
`ifdef FETCH_MISALIGN_CHECK_EN
    @(negedge clk);
    chk("misalign_clr", {31'h0, misalign_err}, 32'h0);
`endif
    cyc(); expect_out("aligned_target", 32'h80, 32'h20);

    // PC wrap and address aliasing
    redirect_to(32'hFFFF_FFF8);
    cyc(); expect_out("wrap0", 32'hFFFF_FFF8, 32'h3FE);
    cyc(); expect_out("wrap1", 32'hFFFF_FFFC, 32'h3FF);
    cyc(); expect_out("wrap2", 32'h0000_0000, 32'h0);
    repeat (3) cyc();

    // Reset again mid-stream; fetch restarts at the reset PC
    reset = 1'b1;
    #1;
    chk("rst2_valid", {31'h0, out_valid}, 32'h0);
    chk("rst2_req",   {31'h0, imem_req},  32'h0);
    repeat (2) cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_req_addr", {22'h0, imem_addr}, {22'h0, RST_PC[11:2]});
    cyc(); expect_out("rst2_s0", RST_PC, memword(RST_PC));
    cyc(); expect_out("rst2_s1", RST_PC + 32'd4, memword(RST_PC + 32'd4));
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
